pid_scheduler: RTL and testbench

Time-multiplexes one shared PID compute engine across `NUM_CH` motor channels. A single period timer generates the control tick and marks each enabled channel pending. A round-robin FSM then hands one channel at a time to the engine with a start/done handshake and latches each result into a per-channel PWM command register. It sits between the register bank and encoder front-ends on one side and the PID engine and PWM generators on the other.

---
 rtl/motor_ctrl_pkg.sv | 25 ++
 rtl/pid_scheduler_if.sv | 33 +++
 rtl/pid_scheduler_rr_arbiter.sv | 40 ++++
 rtl/pid_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_pid_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg
// Shared definitions for the motor-control blocks: the scheduler FSM
// state encoding, the PID datapath width and the default control period.
// No ports (package).
package motor_ctrl_pkg;

  // Width of PID engine results and PWM commands.
  localparam int PID_DATA_W = 16;

  // Default control period in clocks: 10 ms at 100 MHz.
  localparam int DEFAULT_PERIOD = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } sched_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pid_scheduler_if.sv
// pid_scheduler_if
// Handshake between the scheduler and the shared PID engine.
//   eng_sel    : channel index steering setpoint/gains/feedback into the engine
//   eng_start  : one-cycle start pulse
//   eng_done   : one-cycle completion pulse from the engine
//   eng_result : signed, already-clamped engine output
// Modports: master (scheduler side), slave (engine side).
interface pid_scheduler_if
  import motor_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic [SEL_W-1:0]             eng_sel;
  logic                         eng_start;
  logic                         eng_done;
  logic signed [PID_DATA_W-1:0] eng_result;

  modport master (
    output eng_sel,
    output eng_start,
    input  eng_done,
    input  eng_result
  );

  modport slave (
    input  eng_sel,
    input  eng_start,
    output eng_done,
    output eng_result
  );
endinterface

// File: rtl/pid_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first requesting channel strictly
// after last_grant, wrapping around, wins.
//   req         in  NUM_CH : eligible channels
//   last_grant  in  SEL_W  : most recently served channel
//   grant       out NUM_CH : one-hot winner (zero when nothing requests)
//   grant_idx   out SEL_W  : index of the winner
//   grant_valid out 1      : at least one channel requests
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // Scan from the farthest offset to the nearest so that the nearest
    // requester after last_grant is the one left standing.
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = SEL_W'((int'(last_grant) + off) % NUM_CH);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pid_scheduler.sv
// pid_scheduler
// Time-multiplexes one PID engine across NUM_CH motor channels. A period
// timer marks enabled channels pending on each tick; a round-robin FSM
// hands eligible channels to the engine one at a time and latches each
// result into that channel's PWM command register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ch_enable   : per-channel PID enable (disable zeroes the output)
//   fb_valid    : per-channel encoder feedback valid
//   eng         : engine handshake (pid_scheduler_if.master)
//   ch_output   : latched commands, channel i at [16i+15:16i]
//   ch_update   : one-cycle pulse when a channel's output is written
//   overrun     : sticky, tick arrived while channel still pending
//   timeout     : sticky engine watchdog flag
//   flag_clr    : clears overrun and timeout (a same-cycle set wins)
//   busy        : FSM outside IDLE
// Build option: define PID_SCHED_TIMEOUT_EN to build the engine watchdog;
// otherwise WAIT waits indefinitely and timeout is tied low.
// TIMEOUT must be at least 2.
module pid_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PERIOD  = DEFAULT_PERIOD,
  parameter int TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CH-1:0]                   ch_enable,
  input  logic [NUM_CH-1:0]                   fb_valid,
  pid_scheduler_if.master                     eng,
  output logic signed [NUM_CH*PID_DATA_W-1:0] ch_output,
  output logic [NUM_CH-1:0]                   ch_update,
  output logic [NUM_CH-1:0]                   overrun,
  output logic                                timeout,
  input  logic                                flag_clr,
  output logic                                busy
);

  localparam int SEL_W   = sel_width(NUM_CH);
  localparam int TIMER_W = sel_width(PERIOD);
  localparam logic [TIMER_W-1:0] TICK_AT = TIMER_W'(PERIOD - 1);
  localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(NUM_CH - 1);

  // ---------------- period timer ----------------
  logic [TIMER_W-1:0] timer_reg;
  logic               tick;

  assign tick = (timer_reg == TICK_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (tick) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // ---------------- FSM and arbiter ----------------
  sched_state_t      state_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [NUM_CH-1:0] sel_oh_reg;
  logic              start_reg;
  logic              busy_reg;
  logic [SEL_W-1:0]  last_grant_reg;

  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [NUM_CH-1:0] overrun_reg, overrun_next, overrun_set;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              done_accept;
  logic              expire;
  logic [NUM_CH-1:0] finish_vec;

  assign eligible    = pending_reg & ch_enable & fb_valid;
  assign done_accept = (state_reg == ST_WAIT) && eng.eng_done;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req         (eligible),
    .last_grant  (last_grant_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef PID_SCHED_TIMEOUT_EN
  localparam int WCNT_W = sel_width(TIMEOUT + 1);
  logic [WCNT_W-1:0] wait_cnt_reg;
  logic              timeout_reg;

  // The counter reads 1 in the first WAIT cycle, so reaching TIMEOUT-1
  // means TIMEOUT clocks have passed since START. A done in the same
  // cycle still wins.
  assign expire = (state_reg == ST_WAIT) && !eng.eng_done &&
                  (wait_cnt_reg == WCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_START) begin
        wait_cnt_reg <= WCNT_W'(1);
      end else if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (expire) begin
        timeout_reg <= 1'b1;
      end else if (flag_clr) begin
        timeout_reg <= 1'b0;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Channel whose service ends this cycle, by result or by watchdog.
  assign finish_vec = (done_accept || expire) ? sel_oh_reg : '0;

  // Completion clears before the tick sets, so a channel finishing on the
  // tick is re-pended without an overrun. Disabled channels never pend.
  always_comb begin
    pending_next = pending_reg & ~finish_vec;
    if (tick) begin
      pending_next = pending_next | ch_enable;
    end
    pending_next = pending_next & ch_enable;
  end

  assign overrun_set  = tick ? (ch_enable & pending_reg & ~finish_vec) : '0;
  assign overrun_next = (flag_clr ? '0 : overrun_reg) | overrun_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      overrun_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      sel_oh_reg     <= '0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      last_grant_reg <= LAST_CH;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            state_reg  <= ST_SELECT;
            sel_reg    <= grant_idx;
            sel_oh_reg <= grant;
            busy_reg   <= 1'b1;
          end
        end
        ST_SELECT: begin
          // eng_sel has been stable for a cycle; start the engine next.
          state_reg <= ST_START;
          start_reg <= 1'b1;
        end
        ST_START: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_accept || expire) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            last_grant_reg <= sel_reg;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign eng.eng_sel   = sel_reg;
  assign eng.eng_start = start_reg;
  assign busy          = busy_reg;
  assign overrun       = overrun_reg;

  // ---------------- per-channel output registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [PID_DATA_W-1:0] out_reg;
      logic                         update_reg;

      // A disabled channel is held at zero and any result for it is dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg    <= '0;
          update_reg <= 1'b0;
        end else begin
          update_reg <= 1'b0;
          if (!ch_enable[gi]) begin
            out_reg <= '0;
          end else if (done_accept && sel_oh_reg[gi]) begin
            out_reg    <= eng.eng_result;
            update_reg <= 1'b1;
          end
        end
      end

      assign ch_output[gi*PID_DATA_W +: PID_DATA_W] = out_reg;
      assign ch_update[gi] = update_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler
// Directed bench for pid_scheduler with NUM_CH=4, PERIOD=100, TIMEOUT=8 and
// an engine model answering 5 clocks after start with 100+channel.
// Expected updates are queued when a scenario is set up and popped when
// the DUT pulses ch_update. Define PID_SCHED_TIMEOUT_EN to cover the
// watchdog scenario.
module tb_pid_scheduler;
  import motor_ctrl_pkg::*;

  localparam int NCH     = 4;
  localparam int PER     = 100;
  localparam int TMO     = 8;
  localparam int ENG_LAT = 5;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NCH-1:0]                ch_enable;
  logic [NCH-1:0]                fb_valid;
  logic signed [NCH*PID_DATA_W-1:0] ch_output;
  logic [NCH-1:0]                ch_update;
  logic [NCH-1:0]                overrun;
  logic                          timeout;
  logic                          flag_clr;
  logic                          busy;

  pid_scheduler_if #(.NUM_CH(NCH)) eng_if ();

  pid_scheduler #(
    .NUM_CH  (NCH),
    .PERIOD  (PER),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_enable (ch_enable),
    .fb_valid  (fb_valid),
    .eng       (eng_if),
    .ch_output (ch_output),
    .ch_update (ch_update),
    .overrun   (overrun),
    .timeout   (timeout),
    .flag_clr  (flag_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle 0 is the one with the timer at 0.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Engine model: done 5 clocks after start, result = 100 + channel.
  // It ignores rst_n so a late done after a reset really reaches the DUT.
  logic eng_silent = 1'b0;
  int   eng_cnt = 0;
  always @(posedge clk) begin
    eng_if.eng_done <= 1'b0;
    if (eng_cnt == 1) begin
      eng_if.eng_done <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
    if (eng_if.eng_start === 1'b1 && !eng_silent) begin
      eng_cnt <= ENG_LAT - 1;
      eng_if.eng_result <= 16'sd100 + 16'(eng_if.eng_sel);
    end
  end

  int upd_cnt [NCH] = '{default: 0};
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_update[i] === 1'b1) upd_cnt[i] <= upd_cnt[i] + 1;
    end
  end

  typedef struct {
    int          ch;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int base_cnt [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch);
    exp_t e;
    e.ch  = ch;
    e.val = 16'(100 + ch);
    sb_q.push_back(e);
  endtask

  task automatic snap();
    for (int i = 0; i < NCH; i++) base_cnt[i] = upd_cnt[i];
  endtask

  task automatic wait_cyc(input int c);
    int g = 0;
    while (cyc < c && g < 5000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_start(input string tag, input int bound, output int s);
    int k = 0;
    while (k < bound && eng_if.eng_start !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " start seen"}, 64'(eng_if.eng_start), 64'd1);
    s = cyc;
  endtask

  task automatic expect_update(input string tag, input int bound, input int exp_cyc);
    exp_t e;
    logic [NCH-1:0] oh;
    int k = 0;
    while (k < bound && ch_update === '0) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() == 0) begin
      chk({tag, " unexpected update"}, 64'(ch_update), 64'd0);
      return;
    end
    e  = sb_q.pop_front();
    oh = NCH'(1) << e.ch;
    chk({tag, " ch_update"}, 64'(ch_update), 64'(oh));
    chk({tag, " ch_output"}, 64'(ch_output[e.ch*16 +: 16]), 64'(e.val));
    if (exp_cyc >= 0) chk({tag, " update cycle"}, 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    chk({tag, " update pulse width"}, 64'(ch_update), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " eng_sel"},   64'(eng_if.eng_sel),   64'd0);
    chk({tag, " eng_start"}, 64'(eng_if.eng_start), 64'd0);
    chk({tag, " ch_output"}, 64'(ch_output),        64'd0);
    chk({tag, " ch_update"}, 64'(ch_update),        64'd0);
    chk({tag, " overrun"},   64'(overrun),          64'd0);
    chk({tag, " timeout"},   64'(timeout),          64'd0);
    chk({tag, " busy"},      64'(busy),             64'd0);
  endtask

  initial begin
    int s;
    int s2;
    int first_ch;
    ch_enable = '1;
    fb_valid  = '1;
    flag_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // All channels: served 0,1,2,3, starts 8 clocks apart from cycle 102.
    for (int c = 0; c < NCH; c++) push_exp(c);
    for (int c = 0; c < NCH; c++) begin
      wait_start("rr", 200, s);
      chk("rr start cycle", 64'(s), 64'(102 + 8 * c));
      chk("rr eng_sel", 64'(eng_if.eng_sel), 64'(c));
      @(negedge clk);
      chk("rr start one cycle", 64'(eng_if.eng_start), 64'd0);
      chk("rr sel stable in wait", 64'(eng_if.eng_sel), 64'(c));
      chk("rr busy in wait", 64'(busy), 64'd1);
      expect_update("rr", 20, s + 6);
    end
    @(negedge clk);
    for (int c = 0; c < NCH; c++) chk("rr update count", 64'(upd_cnt[c]), 64'd1);

    // Only channel 2 enabled, fresh timer: start at 102, update at 108.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst2");
    ch_enable = 4'b0100;
    rst_n = 1'b1;
    push_exp(2);
    wait_start("ch2", 200, s);
    chk("ch2 start cycle", 64'(s), 64'd102);
    chk("ch2 eng_sel", 64'(eng_if.eng_sel), 64'd2);
    expect_update("ch2", 20, 108);

    // Channel 1 without feedback across two ticks.
    ch_enable = 4'b0010;
    fb_valid  = 4'b1101;
    snap();
    wait_cyc(250);
    chk("fb overrun after 1st tick", 64'(overrun), 64'd0);
    chk("fb not granted", 64'(busy), 64'd0);
    wait_cyc(299);
    chk("fb overrun at 2nd tick", 64'(overrun), 64'd0);
    wait_cyc(300);
    chk("fb overrun after 2nd tick", 64'(overrun), 64'b0010);
    fb_valid = '1;
    push_exp(1);
    wait_start("fb", 10, s);
    chk("fb start cycle", 64'(s), 64'd302);
    chk("fb eng_sel", 64'(eng_if.eng_sel), 64'd1);
    expect_update("fb", 20, 308);
    wait_cyc(320);
    chk("fb served once", 64'(upd_cnt[1] - base_cnt[1]), 64'd1);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("fb overrun cleared", 64'(overrun), 64'd0);

    // Channel 3: one normal service, then disabled while in WAIT.
    ch_enable = 4'b1000;
    push_exp(3);
    wait_start("dis", 100, s);
    chk("dis start cycle", 64'(s), 64'd402);
    expect_update("dis", 20, 408);
    snap();
    wait_start("dis2", 120, s);
    chk("dis2 start cycle", 64'(s), 64'd502);
    wait_cyc(s + 2);
    ch_enable = 4'b0000;
    wait_cyc(s + 3);
    chk("dis output forced 0", 64'(ch_output[3*16 +: 16]), 64'd0);
    wait_cyc(s + 8);
    chk("dis no update", 64'(upd_cnt[3] - base_cnt[3]), 64'd0);
    chk("dis output stays 0", 64'(ch_output[3*16 +: 16]), 64'd0);
    chk("dis back to idle", 64'(busy), 64'd0);

`ifdef PID_SCHED_TIMEOUT_EN
    // Silent engine: watchdog fires 8 clocks after start, next channel goes.
    ch_enable  = 4'b0011;
    eng_silent = 1'b1;
    snap();
    wait_start("tmo", 150, s);
    chk("tmo start cycle", 64'(s), 64'd602);
    chk("tmo eng_sel", 64'(eng_if.eng_sel), 64'd0);
    wait_cyc(s + 7);
    chk("tmo flag before limit", 64'(timeout), 64'd0);
    chk("tmo busy before limit", 64'(busy), 64'd1);
    wait_cyc(s + 8);
    chk("tmo flag at limit", 64'(timeout), 64'd1);
    chk("tmo back to idle", 64'(busy), 64'd0);
    eng_silent = 1'b0;
    push_exp(1);
    wait_start("tmo next", 10, s2);
    chk("tmo next start cycle", 64'(s2), 64'(s + 10));
    chk("tmo next eng_sel", 64'(eng_if.eng_sel), 64'd1);
    expect_update("tmo next", 20, s2 + 6);
    chk("tmo ch0 output kept", 64'(ch_output[0 +: 16]), 64'd0);
    chk("tmo ch0 no update", 64'(upd_cnt[0] - base_cnt[0]), 64'd0);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("tmo flag cleared", 64'(timeout), 64'd0);
    first_ch = 2;
`else
    chk("timeout tied low", 64'(timeout), 64'd0);
    first_ch = 0;
`endif

    // Reset while the second channel of a round is in WAIT.
    ch_enable = '1;
    fb_valid  = '1;
    push_exp(first_ch);
    wait_start("rstw", 250, s);
    chk("rstw first eng_sel", 64'(eng_if.eng_sel), 64'(first_ch));
    expect_update("rstw", 20, s + 6);
    wait_start("rstw2", 20, s);
    wait_cyc(s + 2);
    snap();
    rst_n = 1'b0;
    #1;
    check_reset("rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("late done busy", 64'(busy), 64'd0);
    chk("late done ignored", 64'(ch_update), 64'd0);
    chk("late done no update",
        64'((upd_cnt[0] - base_cnt[0]) + (upd_cnt[1] - base_cnt[1]) +
            (upd_cnt[2] - base_cnt[2]) + (upd_cnt[3] - base_cnt[3])), 64'd0);
    chk("late done outputs", 64'(ch_output), 64'd0);
    push_exp(0);
    wait_start("post rst", 150, s);
    chk("post rst start cycle", 64'(s), 64'd102);
    chk("post rst eng_sel", 64'(eng_if.eng_sel), 64'd0);
    expect_update("post rst", 20, 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
